// File: rtl/aes_encrypt_scheduler.sv
// rtl/aes_encrypt_scheduler.sv - round-robin front end sharing one AES core among NUM_REQ requesters
// One block in flight: operands held for CORE_LATENCY cycles, then ciphertext returned with its requester id.
module aes_encrypt_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int CORE_LATENCY = 11,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   i_Rst_n,
  input  logic [NUM_REQ-1:0]     i_Req_Valid,
  input  logic [NUM_REQ*128-1:0] i_Req_Key,
  input  logic [NUM_REQ*128-1:0] i_Req_Plain_Text,
  output logic [NUM_REQ-1:0]     o_Req_Ready,
  output logic                   o_Rsp_Valid,
  output logic [ID_W-1:0]        o_Rsp_Id,
  output logic [127:0]           o_Rsp_Cipher_Text,
  input  logic                   i_Rsp_Ready,
  output logic [127:0]           o_Core_Key,
  output logic [127:0]           o_Core_Plain_Text,
  input  logic [127:0]           i_Core_Cipher_Text,
  output logic                   o_Busy
);

  localparam int CNT_W = $clog2(CORE_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ID_W-1:0]   last_id;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   idx;
  logic              grant_found;
  logic              accept;

  // Search starts one past the last winner so every waiting requester is reached within NUM_REQ grants.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(last_id) + i) % NUM_REQ);
      if (!grant_found && i_Req_Valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  assign accept = (state == S_IDLE) && grant_found;

  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (grant_found) state_next = S_WAIT;
      S_WAIT: if (cnt == CNT_W'(1)) state_next = S_RESP;
      S_RESP: if (i_Rsp_Ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Ready is masked during reset so no requester sees an accept while the block is held.
  always_comb begin
    o_Req_Ready = '0;
    if (state == S_IDLE && grant_found && i_Rst_n) begin
      o_Req_Ready[grant_id] = 1'b1;
    end
    o_Rsp_Valid = (state == S_RESP);
    o_Busy      = (state != S_IDLE);
  end

  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      last_id           <= ID_W'(NUM_REQ - 1);
      o_Rsp_Id          <= '0;
      cnt               <= '0;
      o_Core_Key        <= '0;
      o_Core_Plain_Text <= '0;
      o_Rsp_Cipher_Text <= '0;
    end else begin
      if (accept) begin
        o_Core_Key        <= i_Req_Key[{grant_id, 7'd0} +: 128];
        o_Core_Plain_Text <= i_Req_Plain_Text[{grant_id, 7'd0} +: 128];
        o_Rsp_Id          <= grant_id;
        last_id           <= grant_id;
        cnt               <= CNT_W'(CORE_LATENCY);
      end else if (state == S_WAIT) begin
        cnt <= cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          o_Rsp_Cipher_Text <= i_Core_Cipher_Text;
        end
      end
    end
  end

endmodule
